prog_load_ctrl: RTL and testbench

Sequencer that brings the single-cycle `riscv_processor` up on the FPGA without a simulator. It receives a program image as a byte stream, writes it word by word into instruction memory and holds the core in reset while loading. It then releases the core for a host-specified cycle budget and freezes it on budget expiry or on a halt indication. It sits between the host byte link (UART receiver) and the core/IMEM write port, replacing the bench-side "count instructions, run N cycles" sequencing.

---
 rtl/prog_load_pkg.sv | 19 +
 rtl/prog_load_ctrl_if.sv | 30 +++
 rtl/prog_load_ctrl_byte_word_packer.sv | 41 ++++
 rtl/prog_load_ctrl.sv | 171 +++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_load_pkg.sv
// Shared types and header layout for the program loader.
// Optional checksum trailer is enabled by PROG_LOAD_CHECKSUM_EN.
package prog_load_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_DONE,
    S_ERR
  } prog_load_state_t;

  localparam int HDR_BYTES = 6;
  localparam int HDR_N_OFF = 0;
  localparam int HDR_B_OFF = 2;

endpackage

// File: rtl/prog_load_ctrl_if.sv
// Host byte link and IMEM write port of the program loader.
// slave = loader side, master = host/memory side.
interface prog_load_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/prog_load_ctrl_byte_word_packer.sv
// Little-endian 8-to-32 assembler; word_valid pulses the cycle
// after the 4th byte and word holds the last assembled value.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_idx;
  logic [23:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx   <= 2'd0;
      acc        <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
      end else if (in_valid) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: acc[7:0]   <= in_data;
          2'd1: acc[15:8]  <= in_data;
          2'd2: acc[23:16] <= in_data;
          default: begin
            word       <= {in_data, acc};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Loads a byte-streamed image into IMEM, then runs the core for a budget.
// Define PROG_LOAD_CHECKSUM_EN to require a trailing XOR checksum byte.
import prog_load_pkg::*;

module prog_load_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int CYCLE_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  prog_load_ctrl_if.slave    bus,
  output logic               core_reset_n,
  output logic               core_en,
  input  logic               core_halt,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CYCLE_W-1:0] cycle_count
);

  prog_load_state_t state, state_nx;

  logic              ready;
  logic              accept;
  logic              word_valid;
  logic              last_word;
  logic              expire;
  logic              hdr_bad;
  logic [31:0]       word;
  logic [2:0]        hdr_idx;
  logic [1:0]        b_sel;
  logic [15:0]       n_words;
  logic [31:0]       budget;
  logic [31:0]       b_full;
  logic [ADDR_W-1:0] addr;
  logic [CYCLE_W-1:0] cnt_nx;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [7:0]        xsum;
`endif

  assign ready = !word_valid &&
    (state inside {S_IDLE, S_HDR, S_LOAD, S_CHK, S_DONE});
  assign accept = bus.rx_valid && ready;

  // Last header byte is still on rx_data when the header is judged.
  assign b_full  = {bus.rx_data, budget[23:0]};
  assign b_sel   = 2'(hdr_idx - 3'(HDR_B_OFF));
  assign hdr_bad = (n_words == 16'd0) ||
    (32'(n_words) > 32'(IMEM_DEPTH)) ||
    (CYCLE_W'(b_full) == '0);

  assign last_word = word_valid &&
    (addr == ADDR_W'(n_words - 16'd1));
  assign cnt_nx = cycle_count + CYCLE_W'(1);
  assign expire = (cnt_nx == CYCLE_W'(budget));

  assign bus.rx_ready   = ready;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = word;

  byte_word_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != S_LOAD),
    .in_valid   (accept && state == S_LOAD),
    .in_data    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    core_reset_n = 1'b0;
    core_en      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        if (accept && hdr_idx == 3'(HDR_BYTES - 1))
          state_nx = hdr_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
`ifdef PROG_LOAD_CHECKSUM_EN
        if (last_word) state_nx = S_CHK;
`else
        if (last_word) state_nx = S_RUN;
`endif
      end
`ifdef PROG_LOAD_CHECKSUM_EN
      S_CHK: begin
        busy = 1'b1;
        if (accept)
          state_nx = (bus.rx_data == xsum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: begin
        core_reset_n = 1'b1;
        core_en      = 1'b1;
        busy         = 1'b1;
        if (expire || core_halt) state_nx = S_DONE;
      end
      S_DONE: begin
        core_reset_n = 1'b1;
        done         = 1'b1;
        if (accept) state_nx = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_idx     <= 3'd0;
      n_words     <= 16'd0;
      budget      <= 32'd0;
      addr        <= '0;
      cycle_count <= '0;
`ifdef PROG_LOAD_CHECKSUM_EN
      xsum        <= 8'd0;
`endif
    end else begin
      if (accept) begin
        if (state == S_IDLE || state == S_DONE) begin
          n_words <= {8'h00, bus.rx_data};
          hdr_idx <= 3'd1;
`ifdef PROG_LOAD_CHECKSUM_EN
          xsum    <= bus.rx_data;
`endif
        end else begin
`ifdef PROG_LOAD_CHECKSUM_EN
          xsum <= xsum ^ bus.rx_data;
`endif
          if (state == S_HDR) begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == 3'(HDR_N_OFF + 1))
              n_words[15:8] <= bus.rx_data;
            else
              budget[{b_sel, 3'b000} +: 8] <= bus.rx_data;
          end
        end
      end

      if (state == S_HDR && state_nx == S_LOAD)
        addr <= '0;
      else if (word_valid)
        addr <= addr + ADDR_W'(1);

      if (state != S_RUN && state_nx == S_RUN)
        cycle_count <= '0;
      else if (state == S_RUN)
        cycle_count <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Random-stimulus bench for prog_load_ctrl with an image-level model.
// Honours PROG_LOAD_CHECKSUM_EN the same way as the design.
module tb_prog_load_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 32;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_halt = 1'b0;
  logic core_reset_n, core_en, busy, done, error;
  logic [CW-1:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  prog_load_ctrl_if #(.ADDR_W(AW)) bus ();

  prog_load_ctrl #(
    .IMEM_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .CYCLE_W    (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .core_en      (core_en),
    .core_halt    (core_halt),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_mode = M_IDLE;
  logic [7:0]  m_img[$];
  bit          m_we = 1'b0;
  int          m_we_addr = 0;
  logic [31:0] m_we_data = '0;
  logic [31:0] m_wdata = '0;
  int          m_addr = 0;
  logic [31:0] m_cnt = '0;
  int          m_n = 0;
  logic [31:0] m_b = '0;
  bit          started = 1'b0;

  logic [31:0] img_words [DEPTH];
  logic [7:0]  img_q[$];
  int          log_addr[$];
  logic [31:0] log_data[$];

  function automatic bit exp_ready();
    return (m_mode == M_IDLE || m_mode == M_LOAD ||
            m_mode == M_DONE) && !m_we;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit acc;
    bit nwe;
    int k;
    logic [7:0] x;
    started = 1'b1;
    if (reset) begin
      m_mode = M_IDLE;
      m_img.delete();
      m_we = 1'b0;
      m_addr = 0;
      m_wdata = '0;
      m_cnt = '0;
    end else begin
      acc = bus.rx_valid && exp_ready();
      nwe = 1'b0;
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (acc) begin
            m_img.delete();
            m_img.push_back(bus.rx_data);
            m_mode = M_LOAD;
          end
        end
        M_LOAD: begin
          if (m_we) begin
            m_addr = (m_addr + 1) % DEPTH;
`ifndef PROG_LOAD_CHECKSUM_EN
            if (m_we_addr == m_n - 1) begin
              m_mode = M_RUN;
              m_cnt = '0;
            end
`endif
          end
          if (acc) begin
            m_img.push_back(bus.rx_data);
            k = m_img.size() - 1;
            if (k == 5) begin
              m_n = int'({m_img[1], m_img[0]});
              m_b = {m_img[5], m_img[4], m_img[3], m_img[2]};
              if (m_n == 0 || m_n > DEPTH || m_b == 0) m_mode = M_ERR;
              else m_addr = 0;
            end else if (k >= 6 && k < 6 + 4 * m_n) begin
              if ((k - 6) % 4 == 3) begin
                nwe = 1'b1;
                m_we_addr = (k - 6) / 4;
                m_we_data = {m_img[k], m_img[k-1], m_img[k-2], m_img[k-3]};
                m_wdata = m_we_data;
              end
            end
`ifdef PROG_LOAD_CHECKSUM_EN
            else if (k == 6 + 4 * m_n) begin
              x = 8'h00;
              for (int i = 0; i < k; i++) x ^= m_img[i];
              if (x == m_img[k]) begin
                m_mode = M_RUN;
                m_cnt = '0;
              end else begin
                m_mode = M_ERR;
              end
            end
`endif
          end
        end
        M_RUN: begin
          m_cnt = m_cnt + 1;
          if (m_cnt == m_b || core_halt) m_mode = M_DONE;
        end
        default: ;
      endcase
      m_we = nwe;
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      check("rx_ready", bus.rx_ready, exp_ready());
      check("imem_we", bus.imem_we, m_we);
      check("imem_addr", bus.imem_addr, m_addr);
      check("imem_wdata", bus.imem_wdata, m_wdata);
      check("core_reset_n", core_reset_n,
            m_mode == M_RUN || m_mode == M_DONE);
      check("core_en", core_en, m_mode == M_RUN);
      check("busy", busy, m_mode == M_LOAD || m_mode == M_RUN);
      check("done", done, m_mode == M_DONE);
      check("error", error, m_mode == M_ERR);
      check("cycle_count", cycle_count, m_cnt);
      if (bus.imem_we) begin
        log_addr.push_back(int'(bus.imem_addr));
        log_data.push_back(bus.imem_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    core_halt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int w;
    if (!hold) begin
      repeat ($urandom_range(0, 2)) begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'($urandom);
        core_halt = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    core_halt = 1'($urandom_range(0, 1));
    w = 0;
    while (!bus.rx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.rx_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    @(negedge clk);
  endtask

  task automatic build_image(input int n, input logic [31:0] b,
                             input bit corrupt);
    logic [15:0] n16;
    logic [7:0] x;
    n16 = 16'(n);
    img_q.delete();
    img_q.push_back(n16[7:0]);
    img_q.push_back(n16[15:8]);
    for (int i = 0; i < 4; i++) img_q.push_back(b[8*i +: 8]);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < 4; i++) img_q.push_back(img_words[j][8*i +: 8]);
`ifdef PROG_LOAD_CHECKSUM_EN
    x = 8'h00;
    foreach (img_q[i]) x ^= img_q[i];
    if (corrupt) x ^= 8'h5A;
    img_q.push_back(x);
`else
    if (corrupt) img_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_end(input int limit);
    int w;
    w = 0;
    while (!(done || error) && w < limit) begin
      @(negedge clk);
      w++;
    end
    if (!(done || error)) check("end_timeout", 0, 1);
  endtask

  task automatic run_image(input int n, input logic [31:0] b,
                           input int halt_at, input bit hold,
                           input bit corrupt);
    int w;
    build_image(n, b, corrupt);
    log_addr.delete();
    log_data.delete();
    foreach (img_q[i]) send_byte(img_q[i], hold);
    bus.rx_valid = 1'b0;
    core_halt = 1'b0;
    if (halt_at > 0) begin
      w = 0;
      while (!core_en && w < 20) begin
        @(negedge clk);
        w++;
      end
      for (int i = 1; i < halt_at && core_en; i++) @(negedge clk);
      if (core_en) begin
        core_halt = 1'b1;
        @(negedge clk);
        core_halt = 1'b0;
      end
    end
    wait_end(int'(b) + 30);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_hdr(input int n, input logic [31:0] b);
    build_image(0, b, 1'b0);
    img_q[0] = 8'(n);
    img_q[1] = 8'(n >> 8);
    for (int i = 0; i < 6; i++) send_byte(img_q[i], 1'b0);
    bus.rx_valid = 1'b0;
    core_halt = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) img_words[i] = $urandom;
  endtask

  initial begin
    int n;
    int b;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_imem_we", bus.imem_we, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_core_reset_n", core_reset_n, 0);
    check("rst_busy", busy, 0);
    check("rst_cycle_count", cycle_count, 0);

    img_words[0] = 32'h00500093;
    img_words[1] = 32'h00A00113;
    img_words[2] = 32'h002081B3;
    run_image(3, 10, 0, 1'b0, 1'b0);
    check("a_done", done, 1);
    check("a_cycles", cycle_count, 10);
    check("a_core_en", core_en, 0);
    check("a_core_reset_n", core_reset_n, 1);
    check("a_nwrites", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("a_addr1", log_addr[1], 1);
      check("a_addr2", log_addr[2], 2);
      check("a_data0", log_data[0], 32'h00500093);
      check("a_data2", log_data[2], 32'h002081B3);
    end

    run_image(3, 10, 4, 1'b1, 1'b0);
    check("h_done", done, 1);
    check("h_cycles", cycle_count, 4);
    check("h_core_en", core_en, 0);
    check("h_nwrites", log_addr.size(), 3);
    if (log_addr.size() == 3)
      check("h_data1", log_data[1], 32'h00A00113);

    build_image(3, 10, 1'b0);
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 14; i++) send_byte(img_q[i], 1'b0);
    bus.rx_valid = 1'b0;
    core_halt = 1'b0;
    for (int w = 0; w < 10 && log_addr.size() < 2; w++) @(negedge clk);
    check("m_words_seen", log_addr.size(), 2);
    do_reset();
    check("m_imem_addr", bus.imem_addr, 0);
    check("m_core_reset_n", core_reset_n, 0);
    check("m_busy", busy, 0);
    rand_words(5);
    run_image(5, 7, 0, 1'b0, 1'b0);
    check("m_done", done, 1);
    check("m_cycles", cycle_count, 7);

    do_reset();
    send_hdr(0, 5);
    check("e0_error", error, 1);
    check("e0_rx_ready", bus.rx_ready, 0);
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("e0_sticky", error, 1);
    check("e0_core_reset_n", core_reset_n, 0);

    do_reset();
    send_hdr(DEPTH + 1, 5);
    check("e1_error", error, 1);
    check("e1_rx_ready", bus.rx_ready, 0);

    do_reset();
    send_hdr(4, 0);
    check("eb_error", error, 1);

    do_reset();
    rand_words(DEPTH);
    run_image(DEPTH, 3, 0, 1'b0, 1'b0);
    check("f_done", done, 1);
    check("f_nwrites", log_addr.size(), DEPTH);
    check("f_addr_wrap", bus.imem_addr, 0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 16);
      b = $urandom_range(1, 40);
      rand_words(n);
      run_image(n, b, $urandom_range(0, 1) ? $urandom_range(1, b + 2) : 0,
                1'($urandom_range(0, 1)), 1'b0);
      check("r_done", done, 1);
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    img_words[0] = 32'h00500093;
    img_words[1] = 32'h00A00113;
    img_words[2] = 32'h002081B3;
    run_image(3, 10, 0, 1'b0, 1'b0);
    check("c_good_done", done, 1);
    check("c_good_cycles", cycle_count, 10);
    run_image(3, 10, 0, 1'b0, 1'b1);
    check("c_bad_error", error, 1);
    check("c_bad_core_reset_n", core_reset_n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
